// File: rtl/image_rom_reader.sv
// Raster-scan fetch sequencer for a 3-cycle-latency image ROM. It buffers the returned
// pixels in a small registered FIFO and emits them on a tagged valid/ready stream.
module image_rom_reader #(
  parameter int IMG_W      = 32,
  parameter int IMG_H      = 32,
  parameter int ADDR_W     = 10,
  parameter int PIX_W      = 24,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       start,
  output logic                       busy,
  output logic                       done,
  output logic                       rom_en,
  output logic [ADDR_W-1:0]          rom_addr,
  input  logic [PIX_W-1:0]           rom_data,
  output logic                       pix_valid,
  input  logic                       pix_ready,
  output logic [PIX_W-1:0]           pix_data,
  output logic [$clog2(IMG_W)-1:0]   pix_x,
  output logic [$clog2(IMG_H)-1:0]   pix_y,
  output logic                       pix_sof,
  output logic                       pix_eol,
  output logic                       pix_eof,
  output logic [1:0]                 fsm_state
);

  localparam int XW = $clog2(IMG_W);
  localparam int YW = $clog2(IMG_H);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(IMG_W * IMG_H - 1);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  typedef struct packed {
    logic [PIX_W-1:0] data;
    logic [XW-1:0]    x;
    logic [YW-1:0]    y;
  } entry_t;

  state_t            state;
  logic [ADDR_W-1:0] addr;
  logic [ADDR_W-1:0] addr_d1;
  logic [XW-1:0]     x_cnt;
  logic [YW-1:0]     y_cnt;
  logic [2:0]        tv;
  logic [XW-1:0]     tx [3];
  logic [YW-1:0]     ty [3];
  entry_t            mem [FIFO_DEPTH];
  entry_t            head;
  logic [PW-1:0]     rd_ptr;
  logic [PW-1:0]     wr_ptr;
  logic [CW-1:0]     fifo_cnt;
  logic [1:0]        inflight;
  logic              issue;
  logic              push;
  logic              pop;

  function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
    return (p == PW'(FIFO_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // Stream handshake: a pixel transfers on every posedge where pix_valid && pix_ready;
  // once pix_valid is high, it and all pix_* fields hold until that transfer happens.
  assign pop       = pix_valid & pix_ready;
  assign push      = tv[2];
  assign inflight  = 2'(tv[0]) + 2'(tv[1]) + 2'(tv[2]);
  // Credit check counts in-flight reads so the FIFO can always absorb what returns.
  assign issue     = (state == RUN) &&
                     (8'(inflight) + 8'(fifo_cnt) < 8'(FIFO_DEPTH) + 8'(pop));
  assign rom_en    = issue;
  assign fsm_state = state;

  assign head      = mem[rd_ptr];
  assign pix_valid = (fifo_cnt != '0);
  assign pix_data  = head.data;
  assign pix_x     = head.x;
  assign pix_y     = head.y;
  assign pix_sof   = pix_valid && (head.x == '0) && (head.y == '0);
  assign pix_eol   = pix_valid && (head.x == XW'(IMG_W - 1));
  assign pix_eof   = pix_eol && (head.y == YW'(IMG_H - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      case (state)
        IDLE:
          if (start) begin
            state <= RUN;
            busy  <= 1'b1;
          end
        RUN:
          if (issue && addr == LAST_ADDR) state <= DRAIN;
        DRAIN:
          // The eof pixel is the last one, so its pop empties an idle pipeline.
          if (pop && fifo_cnt == CW'(1) && inflight == 2'd0) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        DONE: begin
          state <= IDLE;
          done  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr  <= '0;
      x_cnt <= '0;
      y_cnt <= '0;
    end else if (state == IDLE && start) begin
      addr  <= '0;
      x_cnt <= '0;
      y_cnt <= '0;
    end else if (issue) begin
      addr <= addr + 1'b1;
      if (x_cnt == XW'(IMG_W - 1)) begin
        x_cnt <= '0;
        y_cnt <= y_cnt + 1'b1;
      end else begin
        x_cnt <= x_cnt + 1'b1;
      end
    end
  end

  // ROM takes addr two cycles after en; tags ride three stages to meet the data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tv       <= '0;
      addr_d1  <= '0;
      rom_addr <= '0;
      for (int i = 0; i < 3; i++) begin
        tx[i] <= '0;
        ty[i] <= '0;
      end
    end else begin
      tv    <= {tv[1:0], issue};
      tx[0] <= x_cnt;
      ty[0] <= y_cnt;
      tx[1] <= tx[0];
      ty[1] <= ty[0];
      tx[2] <= tx[1];
      ty[2] <= ty[1];
      if (issue) addr_d1 <= addr;
      if (tv[0]) rom_addr <= addr_d1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      fifo_cnt <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= '{data: rom_data, x: tx[2], y: ty[2]};
        wr_ptr      <= ptr_next(wr_ptr);
      end
      if (pop) rd_ptr <= ptr_next(rd_ptr);
      case ({push, pop})
        2'b10:   fifo_cnt <= fifo_cnt + 1'b1;
        2'b01:   fifo_cnt <= fifo_cnt - 1'b1;
        default: fifo_cnt <= fifo_cnt;
      endcase
    end
  end

endmodule

// File: tb/tb_image_rom_reader.sv
// Bench for image_rom_reader: a ROM model with 3-cycle latency, a frame-level expected
// queue of tagged pixels, a per-cycle compare process and directed latency/reset checks.
module tb_image_rom_reader;
  localparam int IMG_W = 32;
  localparam int IMG_H = 32;
  localparam int NPIX  = IMG_W * IMG_H;
  localparam int PIX_W = 24;
  localparam int EW    = PIX_W + 5 + 5 + 3;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             start = 1'b0;
  logic             pix_ready = 1'b0;
  logic             busy, done, rom_en, pix_valid;
  logic [9:0]       rom_addr;
  logic [PIX_W-1:0] rom_data = '0;
  logic [PIX_W-1:0] pix_data;
  logic [4:0]       pix_x, pix_y;
  logic             pix_sof, pix_eol, pix_eof;
  logic [1:0]       fsm_state;

  always #5 clk = ~clk;

  image_rom_reader dut (
    .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done),
    .rom_en(rom_en), .rom_addr(rom_addr), .rom_data(rom_data),
    .pix_valid(pix_valid), .pix_ready(pix_ready), .pix_data(pix_data),
    .pix_x(pix_x), .pix_y(pix_y), .pix_sof(pix_sof), .pix_eol(pix_eol),
    .pix_eof(pix_eof), .fsm_state(fsm_state)
  );

  // ROM model: en seen at edge k, addr taken at edge k+2, data visible after it.
  logic [PIX_W-1:0] rom [NPIX];
  logic [1:0]       en_p = 2'b00;
  always @(posedge clk) begin
    en_p     <= {en_p[0], rom_en};
    rom_data <= en_p[1] ? rom[rom_addr] : PIX_W'($urandom);
  end

  int compared = 0;
  int mismatched = 0;
  int done_cnt = 0;
  int en_cnt = 0;
  int hs_cnt = 0;

  logic [EW-1:0] exp_q[$];
  logic [EW-1:0] dut_word;
  logic [EW-1:0] prev_word = '0;
  logic          prev_valid = 1'b0;
  logic          prev_ready = 1'b0;
  logic          eof_hs_prev = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [EW-1:0] model_word(input int n);
    int x;
    int y;
    x = n % IMG_W;
    y = n / IMG_W;
    return {rom[n], 5'(x), 5'(y), 1'(n == 0), 1'(x == IMG_W - 1), 1'(n == NPIX - 1)};
  endfunction

  task automatic push_frame();
    for (int n = 0; n < NPIX; n++) exp_q.push_back(model_word(n));
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      dut_word = {pix_data, pix_x, pix_y, pix_sof, pix_eol, pix_eof};
      check("done_timing", {63'd0, done}, {63'd0, eof_hs_prev});
      if (done) done_cnt++;
      if (rom_en) en_cnt++;
      if (prev_valid && !prev_ready) begin
        check("stall_valid", {63'd0, pix_valid}, 64'd1);
        check("stall_word", 64'(dut_word), 64'(prev_word));
      end
      eof_hs_prev = 1'b0;
      if (pix_valid) begin
        if (exp_q.size() == 0) begin
          check("unexpected_pixel", {63'd0, pix_valid}, 64'd0);
        end else begin
          check("pixel", 64'(dut_word), 64'(exp_q[0]));
          if (pix_ready) begin
            eof_hs_prev = exp_q[0][0];
            void'(exp_q.pop_front());
            hs_cnt++;
          end
        end
      end
      prev_valid = pix_valid;
      prev_ready = pix_ready;
      prev_word  = dut_word;
    end else begin
      eof_hs_prev = 1'b0;
      prev_valid  = 1'b0;
    end
  end

  task automatic check_all_zero(input string tag);
    check({tag, "_busy"}, {63'd0, busy}, 64'd0);
    check({tag, "_done"}, {63'd0, done}, 64'd0);
    check({tag, "_rom_en"}, {63'd0, rom_en}, 64'd0);
    check({tag, "_rom_addr"}, 64'(rom_addr), 64'd0);
    check({tag, "_valid"}, {63'd0, pix_valid}, 64'd0);
    check({tag, "_data"}, 64'(pix_data), 64'd0);
    check({tag, "_x"}, 64'(pix_x), 64'd0);
    check({tag, "_y"}, 64'(pix_y), 64'd0);
    check({tag, "_flags"}, 64'({pix_sof, pix_eol, pix_eof}), 64'd0);
  endtask

  // Called at posedge+1 of an IDLE cycle; walks the first-pixel latency.
  task automatic start_frame();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check("en_cycle1", {63'd0, rom_en}, 64'd1);
    check("busy_cycle1", {63'd0, busy}, 64'd1);
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("addr_cycle3", 64'(rom_addr), 64'd0);
    @(posedge clk); #1;
    check("valid_cycle4", {63'd0, pix_valid}, 64'd0);
    @(posedge clk); #1;
    check("valid_cycle5", {63'd0, pix_valid}, 64'd1);
    check("data_cycle5", 64'(pix_data), 64'(rom[0]));
    check("sof_cycle5", {63'd0, pix_sof}, 64'd1);
  endtask

  // Returns at posedge+1 of the cycle following the done pulse.
  task automatic wait_done(input bit rnd);
    bit found;
    found = 1'b0;
    for (int i = 0; i < 6000; i++) begin
      @(posedge clk); #1;
      if (done) begin
        found = 1'b1;
        break;
      end
      if (rnd) pix_ready = 1'($urandom_range(0, 1));
    end
    check("done_seen", {63'd0, found}, 64'd1);
    start     = 1'b0;
    pix_ready = 1'b1;
    @(posedge clk); #1;
  endtask

  initial begin
    int d0;
    int e0;
    int h0;
    for (int i = 0; i < NPIX; i++) rom[i] = PIX_W'($urandom);

    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset");
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Full frame with downstream always ready.
    pix_ready = 1'b1;
    d0 = done_cnt;
    h0 = hs_cnt;
    push_frame();
    start_frame();
    wait_done(1'b0);
    check("t1_queue_empty", 64'(exp_q.size()), 64'd0);
    check("t1_done_cnt", 64'(done_cnt - d0), 64'd1);
    check("t1_pixels", 64'(hs_cnt - h0), 64'(NPIX));

    // Downstream stalled: only FIFO_DEPTH reads may be issued.
    pix_ready = 1'b0;
    e0 = en_cnt;
    push_frame();
    start_frame();
    repeat (20) @(posedge clk);
    #1;
    check("t2_en_pulses", 64'(en_cnt - e0), 64'd4);
    check("t2_valid", {63'd0, pix_valid}, 64'd1);
    check("t2_head", 64'(pix_data), 64'(rom[0]));
    pix_ready = 1'b1;
    wait_done(1'b0);
    check("t2_queue_empty", 64'(exp_q.size()), 64'd0);

    // Random back-pressure.
    pix_ready = 1'b1;
    push_frame();
    start_frame();
    wait_done(1'b1);
    check("t3_queue_empty", 64'(exp_q.size()), 64'd0);

    // start held high through RUN and DRAIN must not retrigger.
    d0 = done_cnt;
    push_frame();
    start = 1'b1;
    wait_done(1'b0);
    repeat (10) @(posedge clk);
    #1;
    check("t4_done_cnt", 64'(done_cnt - d0), 64'd1);
    check("t4_idle", {63'd0, busy}, 64'd0);
    check("t4_queue_empty", 64'(exp_q.size()), 64'd0);

    // Asynchronous reset part-way through a frame.
    d0 = done_cnt;
    h0 = hs_cnt;
    push_frame();
    start_frame();
    for (int i = 0; i < 2000 && (hs_cnt - h0) < 500; i++) begin
      @(posedge clk); #1;
    end
    check("t5_reached_500", 64'(hs_cnt - h0 >= 500), 64'd1);
    #3;
    rst_n = 1'b0;
    #1;
    check_all_zero("t5_reset");
    exp_q.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
    check("t5_no_done", 64'(done_cnt - d0), 64'd0);

    // Fresh frame after reset, then a back-to-back frame.
    d0 = done_cnt;
    push_frame();
    start_frame();
    wait_done(1'b0);
    check("t6_busy_gap", {63'd0, busy}, 64'd0);
    push_frame();
    start_frame();
    wait_done(1'b0);
    check("t6_done_cnt", 64'(done_cnt - d0), 64'd2);
    check("t6_queue_empty", 64'(exp_q.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
